store_write_buffer: RTL

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of {address, data} stores drained to memory.
// Define STORE_WRITE_BUFFER_FWD_EN to build store-to-load forwarding.
`timescale 1ns/1ps
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        MemReqValid,
    input  logic        MemReqReady,
    output logic [31:0] MemReqAdr,
    output logic [31:0] MemReqData,
    output logic        FwdHit,
    output logic [31:0] FwdData,
    output logic        Empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   adr_q [DEPTH];
    logic [31:0]   adr_d [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   dat_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic valid;
    logic enq;
    logic deq;

    always_comb begin
        full        = (count_q == FULL);
        valid       = (count_q != '0);
        // A full buffer refuses the store even when the head drains this cycle.
        enq         = MemWrite & ~full & ~reset;
        deq         = valid & MemReqReady & ~reset;
        Stall       = MemWrite & full;
        MemReqValid = valid;
        Empty       = ~valid;
        MemReqAdr   = valid ? adr_q[head_q] : 32'h0;
        MemReqData  = valid ? dat_q[head_q] : 32'h0;
    end

    always_comb begin
        adr_d   = adr_q;
        dat_d   = dat_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            adr_d[tail_q] = DataAdr;
            dat_d[tail_q] = WriteData;
            tail_d        = tail_q + AW'(1);
        end
        if (deq) begin
            head_d = head_q + AW'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q   <= '{default: '0};
            dat_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef STORE_WRITE_BUFFER_FWD_EN
    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx     = '0;
        FwdHit  = 1'b0;
        FwdData = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q && adr_q[idx][31:2] == DataAdr[31:2]) begin
                FwdHit  = 1'b1;
                FwdData = dat_q[idx];
            end
        end
    end
`else
    assign FwdHit  = 1'b0;
    assign FwdData = 32'h0;
`endif

endmodule
